// File: rtl/ammrv_arbiter2.sv
// ammrv_arbiter2: shares one Avalon-MM slave between two masters, one transaction outstanding at a time
module ammrv_arbiter2 #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int          TIMEOUT     = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] s0_address,
  input  logic [3:0]  s0_byteenable,
  input  logic [31:0] s0_writedata,
  input  logic        s0_read,
  input  logic        s0_write,
  output logic        s0_waitrequest,
  output logic [31:0] s0_readdata,
  output logic        s0_readdatavalid,
  input  logic [31:0] s1_address,
  input  logic [3:0]  s1_byteenable,
  input  logic [31:0] s1_writedata,
  input  logic        s1_read,
  input  logic        s1_write,
  output logic        s1_waitrequest,
  output logic [31:0] s1_readdata,
  output logic        s1_readdatavalid,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  output logic        m_read,
  output logic        m_write,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        timeout
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;
  state_t          state_q;
  logic            gnt_q, last_q;
  logic [TW-1:0]   tcnt_q;
  logic            req0, req1, win, g_read, g_write, in_cmd, in_rdw, acc, deliver, tmo;
  // arbitration decision, granted-master command mux and response qualification
  always_comb begin
    req0    = s0_read | s0_write;
    req1    = s1_read | s1_write;
    win     = (req0 && req1) ? (ROUND_ROBIN ? ~last_q : 1'b0) : req1;
    g_read  = gnt_q ? s1_read : s0_read;
    g_write = gnt_q ? s1_write : s0_write;
    in_cmd  = state_q == CMD;
    in_rdw  = state_q == RDWAIT;
    acc     = in_cmd && !m_waitrequest;
    deliver = (acc && g_read && m_readdatavalid) || (in_rdw && m_readdatavalid);
    tmo     = in_rdw && (TIMEOUT != 0) && (tcnt_q == TLAST) && !m_readdatavalid;
  end
  assign m_address        = gnt_q ? s1_address : s0_address;
  assign m_byteenable     = gnt_q ? s1_byteenable : s0_byteenable;
  assign m_writedata      = gnt_q ? s1_writedata : s0_writedata;
  assign m_read           = in_cmd && g_read;
  assign m_write          = in_cmd && g_write;
  assign s0_waitrequest   = (in_cmd && !gnt_q) ? m_waitrequest : 1'b1;
  assign s1_waitrequest   = (in_cmd && gnt_q) ? m_waitrequest : 1'b1;
  assign s0_readdatavalid = (deliver || tmo) && !gnt_q;
  assign s1_readdatavalid = (deliver || tmo) && gnt_q;
  assign s0_readdata      = (tmo && !gnt_q) ? ERR_DATA : m_readdata;
  assign s1_readdata      = (tmo && gnt_q) ? ERR_DATA : m_readdata;
  assign timeout          = tmo;
  // transaction FSM: grant in IDLE, hold through acceptance, then wait for read data or timeout
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
    end else if (state_q == IDLE) begin
      if (req0 || req1) begin
        gnt_q   <= win;
        state_q <= CMD;
      end
    end else if (state_q == CMD) begin
      if (acc) begin
        last_q  <= gnt_q;
        tcnt_q  <= '0;
        state_q <= (g_read && !m_readdatavalid) ? RDWAIT : IDLE;
      end
    end else if (state_q == RDWAIT) begin
      if (m_readdatavalid || tmo) state_q <= IDLE;
      else tcnt_q <= tcnt_q + 1'b1;
    end else begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_ammrv_arbiter2.sv
// tb_ammrv_arbiter2: two arbiters (round-robin + 8-cycle timeout, fixed-priority + no timeout) against a transaction-level model
module tb_ammrv_arbiter2;
  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] s0_address, s0_writedata, s1_address, s1_writedata, m_readdata;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_read, s0_write, s1_read, s1_write, m_waitrequest, m_readdatavalid;
  logic [1:0][31:0] m_address, m_writedata, s0_rd, s1_rd;
  logic [1:0][3:0]  m_byteenable;
  logic [1:0] m_read, m_write, s0_wr, s1_wr, s0_rdv, s1_rdv, tmo_o;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ammrv_arbiter2 #(.ROUND_ROBIN(g == 0), .TIMEOUT(g == 0 ? 8 : 0), .ERR_DATA(32'hDEADBEEF)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
      .s0_read(s0_read), .s0_write(s0_write), .s0_waitrequest(s0_wr[g]),
      .s0_readdata(s0_rd[g]), .s0_readdatavalid(s0_rdv[g]),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_read(s1_read), .s1_write(s1_write), .s1_waitrequest(s1_wr[g]),
      .s1_readdata(s1_rd[g]), .s1_readdatavalid(s1_rdv[g]),
      .m_address(m_address[g]), .m_byteenable(m_byteenable[g]), .m_writedata(m_writedata[g]),
      .m_read(m_read[g]), .m_write(m_write[g]), .m_waitrequest(m_waitrequest),
      .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .timeout(tmo_o[g]));
  end
  task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h expected=%h at %0t", n, k, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // transaction-level model: who owns the bus, whether the command was accepted, cycles since acceptance
  bit busy[2], own[2], accd[2], last[2];
  int cnt[2];
  initial for (int k = 0; k < 2; k++) begin
    busy[k] = 0; own[k] = 0; accd[k] = 0; last[k] = 1; cnt[k] = 0;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit rq0, rq1, g_rd, g_wr, cmd, e_to, e_del, e_rdv0, e_rdv1;
      int tlim;
      tlim = (k == 0) ? 8 : 0;
      rq0 = s0_read | s0_write;
      rq1 = s1_read | s1_write;
      g_rd = own[k] ? s1_read : s0_read;
      g_wr = own[k] ? s1_write : s0_write;
      cmd = busy[k] && !accd[k];
      e_to = busy[k] && accd[k] && tlim != 0 && cnt[k] == tlim && !m_readdatavalid;
      e_del = (cmd && !m_waitrequest && g_rd && m_readdatavalid) || (busy[k] && accd[k] && m_readdatavalid);
      e_rdv0 = (e_del || e_to) && !own[k];
      e_rdv1 = (e_del || e_to) && own[k];
      chk("m_read", k, 32'(m_read[k]), 32'(cmd && g_rd));
      chk("m_write", k, 32'(m_write[k]), 32'(cmd && g_wr));
      if (cmd && (g_rd || g_wr)) begin
        chk("m_address", k, m_address[k], own[k] ? s1_address : s0_address);
        chk("m_writedata", k, m_writedata[k], own[k] ? s1_writedata : s0_writedata);
        chk("m_byteenable", k, 32'(m_byteenable[k]), 32'(own[k] ? s1_byteenable : s0_byteenable));
      end
      chk("s0_waitrequest", k, 32'(s0_wr[k]), 32'((cmd && !own[k]) ? m_waitrequest : 1'b1));
      chk("s1_waitrequest", k, 32'(s1_wr[k]), 32'((cmd && own[k]) ? m_waitrequest : 1'b1));
      chk("s0_readdatavalid", k, 32'(s0_rdv[k]), 32'(e_rdv0));
      chk("s1_readdatavalid", k, 32'(s1_rdv[k]), 32'(e_rdv1));
      chk("timeout", k, 32'(tmo_o[k]), 32'(e_to));
      if (e_rdv0) chk("s0_readdata", k, s0_rd[k], e_to ? 32'hDEADBEEF : m_readdata);
      if (e_rdv1) chk("s1_readdata", k, s1_rd[k], e_to ? 32'hDEADBEEF : m_readdata);
      if (!reset_n) begin
        busy[k] <= 0; accd[k] <= 0; last[k] <= 1; cnt[k] <= 0; own[k] <= 0;
      end else if (!busy[k]) begin
        if (rq0 || rq1) begin
          busy[k] <= 1;
          accd[k] <= 0;
          own[k] <= (rq0 && rq1) ? ((k == 0) ? !last[k] : 1'b0) : rq1;
        end
      end else if (!accd[k]) begin
        if (!m_waitrequest) begin
          last[k] <= own[k];
          if (g_rd && !m_readdatavalid) begin
            accd[k] <= 1;
            cnt[k] <= 1;
          end else busy[k] <= 0;
        end
      end else if (m_readdatavalid || e_to) busy[k] <= 0;
      else cnt[k] <= cnt[k] + 1;
    end
  end
  initial begin
    reset_n = 0;
    {s0_address, s0_writedata, s1_address, s1_writedata, m_readdata} = '0;
    {s0_byteenable, s1_byteenable} = '0;
    {s0_read, s0_write, s1_read, s1_write, m_waitrequest, m_readdatavalid} = '0;
    repeat (3) tick();
    reset_n = 1;
    repeat (10) tick();
    @(negedge clk);
    chk("idle_m_read", 0, 32'(m_read[0]), 32'd0);
    chk("idle_s0_wait", 0, 32'(s0_wr[0]), 32'd1);
    chk("idle_timeout", 0, 32'(tmo_o[0]), 32'd0);
    tick();
    s0_write = 1; s0_address = 32'h10; s0_writedata = 32'h12345678; s0_byteenable = 4'hF;
    tick();
    @(negedge clk);
    chk("wr_m_write", 0, 32'(m_write[0]), 32'd1);
    chk("wr_m_address", 0, m_address[0], 32'h10);
    chk("wr_m_writedata", 0, m_writedata[0], 32'h12345678);
    chk("wr_s0_wait", 0, 32'(s0_wr[0]), 32'd0);
    chk("wr_s1_wait", 0, 32'(s1_wr[0]), 32'd1);
    tick();
    s0_write = 0;
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    s0_write = 1; s0_address = 32'h100; s1_write = 1; s1_address = 32'h200;
    for (int i = 0; i < 7; i++) begin
      tick();
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("rr_m_write", 0, 32'(m_write[0]), 32'd1);
        chk("rr_grant_addr", 0, m_address[0], ((i / 2) % 2 == 1) ? 32'h200 : 32'h100);
        chk("fp_grant_addr", 1, m_address[1], 32'h100);
      end else begin
        chk("rr_gap", 0, 32'(m_write[0]), 32'd0);
      end
    end
    tick();
    s0_write = 0; s1_write = 0;
    tick();
    s1_read = 1; s1_address = 32'h300; m_waitrequest = 1;
    tick();
    s0_write = 1; s0_address = 32'h400; s0_writedata = 32'h55AA55AA;
    tick();
    tick();
    tick();
    m_waitrequest = 0;
    @(negedge clk);
    chk("rd_s1_wait", 0, 32'(s1_wr[0]), 32'd0);
    chk("rd_m_read", 0, 32'(m_read[0]), 32'd1);
    chk("rd_m_address", 0, m_address[0], 32'h300);
    tick();
    s1_read = 0;
    tick();
    m_readdatavalid = 1; m_readdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rd_s1_rdv", 0, 32'(s1_rdv[0]), 32'd1);
    chk("rd_s1_data", 0, s1_rd[0], 32'hCAFEF00D);
    chk("rd_s0_rdv", 0, 32'(s0_rdv[0]), 32'd0);
    tick();
    m_readdatavalid = 0; m_readdata = 0;
    @(negedge clk);
    chk("pend_not_yet", 0, 32'(m_write[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("pend_m_write", 0, 32'(m_write[0]), 32'd1);
    chk("pend_m_address", 0, m_address[0], 32'h400);
    tick();
    s0_write = 0;
    tick();
    s0_read = 1; s0_address = 32'h500;
    tick();
    tick();
    s0_read = 0;
    repeat (6) tick();
    @(negedge clk);
    chk("to_early", 0, 32'(tmo_o[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("to_pulse", 0, 32'(tmo_o[0]), 32'd1);
    chk("to_s0_rdv", 0, 32'(s0_rdv[0]), 32'd1);
    chk("to_s0_data", 0, s0_rd[0], 32'hDEADBEEF);
    chk("to_disabled", 1, 32'(tmo_o[1]), 32'd0);
    tick();
    tick();
    m_readdatavalid = 1; m_readdata = 32'h0BADF00D;
    @(negedge clk);
    chk("late_dropped", 0, 32'(s0_rdv[0]), 32'd0);
    chk("late_no_to_rdv", 1, 32'(s0_rdv[1]), 32'd1);
    chk("late_no_to_data", 1, s0_rd[1], 32'h0BADF00D);
    tick();
    m_readdatavalid = 0;
    tick();
    s0_read = 1;
    tick();
    tick();
    s0_read = 0;
    repeat (7) tick();
    m_readdatavalid = 1; m_readdata = 32'h11223344;
    @(negedge clk);
    chk("tie_no_to", 0, 32'(tmo_o[0]), 32'd0);
    chk("tie_rdv", 0, 32'(s0_rdv[0]), 32'd1);
    chk("tie_data", 0, s0_rd[0], 32'h11223344);
    tick();
    m_readdatavalid = 0;
    tick();
    s1_read = 1; s1_address = 32'h600;
    tick();
    tick();
    s1_read = 0; reset_n = 0;
    tick();
    reset_n = 1; m_readdatavalid = 1; m_readdata = 32'h77;
    @(negedge clk);
    chk("abort_s1_rdv", 0, 32'(s1_rdv[0]), 32'd0);
    chk("abort_s1_rdv", 1, 32'(s1_rdv[1]), 32'd0);
    chk("abort_s0_wait", 0, 32'(s0_wr[0]), 32'd1);
    chk("abort_s1_wait", 0, 32'(s1_wr[0]), 32'd1);
    tick();
    m_readdatavalid = 0;
    repeat (3) tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ammrv_arbiter2.md
# ammrv_arbiter2

Two-requester arbiter that shares one 32-bit Avalon-MM slave port between two Avalon-MM masters, e.g. a CPU data port and a DMA engine in front of a retimed peripheral bus. Exactly one transaction is outstanding at a time. Each grant stays held until the write is accepted or the read data returns, and read data is routed back to the owning master. An optional read timeout returns an error word so that a dead slave cannot hang the bus.

## Interface
- ROUND_ROBIN, 1: 1 = alternate on contention; 0 = fixed priority, master 0 wins.
- TIMEOUT, 0: cycles to wait for m_readdatavalid after read acceptance; 0 = disabled.
- ERR_DATA, 32'hDEADBEEF: readdata returned on a read timeout.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- s0_address, s1_address  in  32  per-master address.
- s0_byteenable, s1_byteenable  in  4  per-master byte enables.
- s0_writedata, s1_writedata  in  32  per-master write data.
- s0_read, s1_read / s0_write, s1_write  in  1  per-master command strobes; read and write are never both high for one master.
- s0_waitrequest, s1_waitrequest  out  1  per-master stall.
- s0_readdata, s1_readdata  out  32  read data.
- s0_readdatavalid, s1_readdatavalid  out  1  read data valid.
- m_address / m_byteenable / m_writedata  out  32/4/32  slave-side command.
- m_read, m_write  out  1  slave-side strobes.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  32  slave read data.
- m_readdatavalid  in  1  slave read data valid.
- timeout  out  1  one-cycle pulse when a read times out.

## Operation
- req_i = si_read | si_write. Registers: state {IDLE, CMD, RDWAIT}, gnt (1 bit), last (1 bit), tcnt ($clog2(TIMEOUT+1) bits).
- IDLE
  - m_read = m_write = 0; both s_waitrequest = 1.
  - If any req_i, choose the winner, load gnt, and go to CMD.
  - Single requester: that requester wins.
  - Both requesting, ROUND_ROBIN=1: winner = ~last.
  - Both requesting, ROUND_ROBIN=0: master 0 wins.
- CMD
  - m_address, m_byteenable, m_writedata, m_read and m_write are driven combinationally from master gnt.
  - s<gnt>_waitrequest = m_waitrequest; the other master's waitrequest = 1.
  - On m_waitrequest=0, last <= gnt.
  - If the command was a write, go to IDLE.
  - If the command was a read and m_readdatavalid is high in the same cycle, deliver the data and go to IDLE.
  - Otherwise, for a read, clear tcnt and go to RDWAIT.
- RDWAIT
  - m_read = m_write = 0; both waitrequest = 1.
  - On m_readdatavalid: s<gnt>_readdatavalid = 1, then go to IDLE.
  - Otherwise, if TIMEOUT≠0 and tcnt == TIMEOUT-1: s<gnt>_readdatavalid = 1, s<gnt>_readdata = ERR_DATA, timeout = 1, then go to IDLE.
  - Otherwise tcnt increments.
  - Data and timeout in the same cycle: data wins and timeout stays 0.
- s0_readdata and s1_readdata = m_readdata, except on the timeout cycle.
- s_readdatavalid is combinational from m_readdatavalid, gated by state and gnt.
- m_readdatavalid in IDLE, or in CMD before acceptance, is dropped (a late response after a timeout). No master sees it.
- A master that drops its request while in CMD is a protocol violation; behaviour is undefined.

## Timing
- Reset (reset_n=0 at a clock edge):
  - state = IDLE, gnt = 0, last = 1 (so master 0 wins the first tie), tcnt = 0.
  - Outputs: m_read = m_write = 0, s0/s1_waitrequest = 1, s*_readdatavalid = 0, timeout = 0.
  - m_address, m_byteenable and m_writedata are don't-care while m_read = m_write = 0.
- Reset mid-transaction aborts to IDLE without a response. A response arriving afterwards is dropped.
- Grant latency: a request sampled in IDLE at cycle N appears on m_* in cycle N+1.
- Zero-wait write: s_waitrequest is low in cycle N+1. The next grant is decided in cycle N+2, so the peak rate is one transaction per 2 cycles.
- Read: s readdatavalid appears in the same cycle as m_readdatavalid, with no added latency.
- A timeout fires exactly TIMEOUT cycles after the cycle in which the read was accepted.

## Test plan
- Reset, then no requests: all outputs hold their reset values for 10 cycles, and m_read = m_write = 0 throughout.
- Master 0 writes addr 0x10, data 0x12345678, byteenable 0xF, with m_waitrequest=0: m_write=1 with those values in cycle 1, s0_waitrequest=0 in cycle 1, s1_waitrequest=1 throughout.
- Both masters request writes continuously, ROUND_ROBIN=1: grants go 0,1,0,1; each m_write pulse is 2 cycles apart; no master is granted twice in a row. With ROUND_ROBIN=0, master 0 takes every grant.
- Master 1 reads, the slave holds m_waitrequest for 3 cycles and returns 0xCAFEF00D 2 cycles after acceptance: s1_readdatavalid=1 with 0xCAFEF00D; s0_readdatavalid stays 0; master 0's pending request is granted only in the cycle after the data.
- TIMEOUT=8, master 0 reads, and the slave never returns data: s0_readdatavalid=1 with 0xDEADBEEF and timeout=1 exactly 8 cycles after acceptance. A late m_readdatavalid 2 cycles after that is dropped.
- Deassert reset_n while in RDWAIT: next cycle state is IDLE, all waitrequests = 1, and no readdatavalid is emitted for the aborted read.
